// File: rtl/vec_mem_pkg.sv
// Shared widths, FSM state encoding and the 32-bit lane slice helper for the vector memory arbiter.
package vec_mem_pkg;

    localparam int ADDR_W = 9;
    localparam int LANES  = 16;
    localparam int DATA_W = LANES * 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [31:0] lane_word(input logic [DATA_W-1:0] vec, input int j);
        return vec[j*32 +: 32];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping modulo N.
// Zero latency; no state, the caller owns the pointer and decides when a grant is taken.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/vec_mem_arbiter.sv
// Round-robin sequencer for the single-port vector memory: accept, one ACCESS cycle, then hold the response.
// Accept edge to rsp_valid is 2 posedges, one access per 3 cycles; a stalled response blocks all new grants.
module vec_mem_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = vec_mem_pkg::ADDR_W,
    parameter int DATA_W = vec_mem_pkg::DATA_W,
    parameter int LANES  = vec_mem_pkg::LANES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mem_we,
    input  logic [DATA_W-1:0]       mem_rdata
);

    import vec_mem_pkg::state_t;
    import vec_mem_pkg::ST_IDLE;
    import vec_mem_pkg::ST_ACCESS;
    import vec_mem_pkg::ST_RESP;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [N_REQ-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    id_d        = gnt_idx;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we;
                    rr_ptr_d    = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The store has landed on the negedge, so this capture is the post-write read-back.
                for (int j = 0; j < LANES; j++) begin
                    rsp_data_d[j*32 +: 32] = mem_rdata[j*32 +: 32];
                end
                mem_we_d = 1'b0;
                for (int i = 0; i < N_REQ; i++) begin
                    rsp_valid_d[i] = (int'(id_q) == i);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q[id_q] && rsp_ready[id_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                mem_we_d    = 1'b0;
                rsp_valid_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Ready is masked by reset so nothing looks accepted while the block is held in reset.
    assign req_ready = (state_q == ST_IDLE && reset_n) ? gnt : '0;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Randomized scoreboard bench for vec_mem_arbiter with a word-addressed memory model and shadow-memory reference.
module tb_vec_mem_arbiter;
    import vec_mem_pkg::*;

    localparam int N  = 2;
    localparam int AW = ADDR_W;
    localparam int DW = DATA_W;
    localparam int NW = 512;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_data, mem_wdata, mem_rdata;
    logic            busy, mem_we;
    logic [AW-1:0]   mem_addr;

    vec_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LANES(LANES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          last_acc = -1;
    bit          contend = 1'b0;
    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name, input int cycles);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no completion within %0d cycles (t=%0t)", name, cycles, $time);
    endtask

    // Memory: negedge write of 16 consecutive words wrapping at 512, combinational read.
    initial begin : memory_model
        for (int k = 0; k < NW; k++) mem[k] = 32'(k);
        forever begin
            @(negedge clk);
            if (mem_we) begin
                for (int j = 0; j < LANES; j++) mem[(int'(mem_addr) + j) % NW] = lane_word(mem_wdata, j);
            end
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int j = 0; j < LANES; j++) mem_rdata[j*32 +: 32] = mem[(int'(mem_addr) + j) % NW];
    end

    // Reference arbiter: decides who should be accepted and pushes the expected response.
    initial begin : ref_model
        int            win;
        logic [N-1:0]  exp_rdy;
        exp_t          e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                exp_q.delete();
                m_ptr    = 0;
                last_acc = -1;
            end else begin
                chk("busy", DW'(busy), DW'(exp_q.size() != 0));
                exp_rdy = '0;
                if (exp_q.size() == 0) begin
                    win = -1;
                    for (int k = 0; k < N; k++) begin
                        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                    end
                    if (win >= 0) begin
                        exp_rdy[win] = 1'b1;
                        e.id      = win;
                        e.we      = req_we[win];
                        e.addr    = req_addr[win*AW +: AW];
                        e.acc_cyc = cyc;
                        if (e.we) e.data = req_wdata[win*DW +: DW];
                        else for (int j = 0; j < LANES; j++) e.data[j*32 +: 32] = ref_mem[(int'(e.addr) + j) % NW];
                        exp_q.push_back(e);
                        m_ptr = (win + 1) % N;
                        if (contend && last_acc >= 0) chk("accept_period", DW'(cyc - last_acc), DW'(3));
                        last_acc = cyc;
                    end
                end
                if (req_valid != '0) chk("req_ready", DW'(req_ready), DW'(exp_rdy));
            end
        end
    end

    // Monitor: compares what the DUT presents against the head of the expected queue.
    initial begin : monitor
        exp_t         e;
        int           age;
        logic [N-1:0] oh;
        for (int k = 0; k < NW; k++) ref_mem[k] = 32'(k);
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) continue;
            if (exp_q.size() == 0) begin
                chk("rsp_valid_idle", DW'(rsp_valid), DW'(0));
            end else begin
                e   = exp_q[0];
                age = cyc - e.acc_cyc;
                if (age < 2) begin
                    chk("rsp_valid_early", DW'(rsp_valid), DW'(0));
                    if (age == 1) begin
                        chk("mem_we", DW'(mem_we), DW'(e.we));
                        chk("mem_addr", DW'(mem_addr), DW'(e.addr));
                        if (e.we) chk("mem_wdata", mem_wdata, e.data);
                    end
                end else begin
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("rsp_valid", DW'(rsp_valid), DW'(oh));
                    chk("rsp_data", rsp_data, e.data);
                    if (rsp_ready[e.id]) begin
                        if (e.we) for (int j = 0; j < LANES; j++) ref_mem[(int'(e.addr) + j) % NW] = e.data[j*32 +: 32];
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[id]             = we;
        req_addr[id*AW +: AW]  = a;
        req_wdata[id*DW +: DW] = d;
        req_valid[id]          = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int j = 0; j < LANES; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic randomize_req(input int id);
        req_we[id]             = 1'($urandom_range(0, 1));
        req_addr[id*AW +: AW]  = AW'($urandom);
        req_wdata[id*DW +: DW] = rand_vec();
    endtask

    // Returns just after the accept posedge (inputs may be changed from here on).
    task automatic wait_accept(input int id, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id] && req_valid[id]) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) timeout(name, 50);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) timeout(name, 200);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1);
    end

    initial begin : stimulus
        logic [DW-1:0] wd;
        logic [N-1:0]  acc;
        int            grants;
        int            bad_words;
        bit            seen;

        reset_n   = 1'b0;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '1;
        #3;
        chk("reset_req_ready", DW'(req_ready), DW'(0));
        chk("reset_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("reset_busy", DW'(busy), DW'(0));
        chk("reset_mem_we", DW'(mem_we), DW'(0));
        chk("reset_mem_addr", DW'(mem_addr), DW'(0));
        chk("reset_mem_wdata", mem_wdata, '0);
        chk("reset_rsp_data", rsp_data, '0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single load from requester 0.
        drive_req(0, 1'b0, 9'h010, '0);
        wait_accept(0, "t1_accept");
        req_valid[0] = 1'b0;
        wait_idle("t1_idle");

        // Store that wraps past the top of memory, then a load of the wrapped words.
        for (int j = 0; j < LANES; j++) wd[j*32 +: 32] = 32'hA0 + 32'(j);
        drive_req(1, 1'b1, 9'h1F8, wd);
        wait_accept(1, "t2_store_accept");
        req_valid[1] = 1'b0;
        wait_idle("t2_store_idle");
        chk("wrap_word_1ff", DW'(mem[9'h1FF]), DW'(32'hA7));
        chk("wrap_word_000", DW'(mem[9'h000]), DW'(32'hA8));
        chk("wrap_word_008", DW'(mem[9'h008]), DW'(32'h08));
        drive_req(0, 1'b0, 9'h000, '0);
        wait_accept(0, "t2_load_accept");
        req_valid[0] = 1'b0;
        wait_idle("t2_load_idle");

        // Reset while a store sits in ACCESS, before its commit negedge.
        drive_req(0, 1'b1, 9'h020, rand_vec());
        wait_accept(0, "t5_accept");
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_mid_mem_we", DW'(mem_we), DW'(0));
        chk("rst_mid_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_mid_busy", DW'(busy), DW'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int j = 0; j < LANES; j++) chk("rst_store_dropped", DW'(mem[9'h020 + 9'(j)]), DW'(32'h20 + 32'(j)));

        // Continuous contention right after reset; the accepted requester's inputs change just after acceptance.
        contend = 1'b1;
        for (int i = 0; i < N; i++) randomize_req(i);
        req_valid = '1;
        grants = 0;
        for (int c = 0; c < 60 && grants < 12; c++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    randomize_req(i);
                    grants++;
                end
            end
        end
        if (grants < 12) timeout("contention_grants", 60);
        contend   = 1'b0;
        req_valid = '0;
        wait_idle("t3_idle");

        // Backpressure on requester 0 while requester 1 waits.
        rsp_ready = 2'b10;
        drive_req(0, 1'b0, AW'($urandom), '0);
        wait_accept(0, "t4_accept0");
        req_valid[0] = 1'b0;
        drive_req(1, 1'b0, AW'($urandom), '0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        if (!seen) timeout("t4_rsp_valid", 20);
        repeat (5) @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        wait_accept(1, "t4_accept1");
        req_valid[1] = 1'b0;
        rsp_ready    = '1;
        wait_idle("t4_idle");

        // Random traffic with random response backpressure.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = ~req_valid[i];
                    randomize_req(i);
                end
            end
            rsp_ready = N'($urandom);
        end
        req_valid = '0;
        rsp_ready = '1;
        wait_idle("random_idle");

        bad_words = 0;
        for (int k = 0; k < NW; k++) if (mem[k] !== ref_mem[k]) bad_words++;
        chk("final_mem_words_differing", DW'(bad_words), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
